// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter measurement path.
// - state_e   : measurement sequencer states
// - RANGE_*   : gate range encoding (also the decimal-point position)
// - gate_len(): gate length in reference-clock cycles for a range
package freq_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StLock
  } state_e;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  // Intended for elaboration-time constants only.
  function automatic int unsigned gate_len(input logic [1:0] range,
                                           input int unsigned clk_freq_hz);
    int unsigned len;
    case (range)
      RANGE_1S:    len = clk_freq_hz;
      RANGE_100MS: len = clk_freq_hz / 10;
      default:     len = clk_freq_hz / 100;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter used for both the gate and the settle interval.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i (takes priority over en_i)
//   load_val_i : interval length in cycles
//   en_i       : count down one per cycle
//   done_o     : high during the last enabled cycle of the interval
module gate_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  // Loading N yields exactly N enabled cycles, the last one flagged here.
  assign done_o = en_i && (count_q == Width'(1));

endmodule

// File: rtl/freq_gate_sequencer.sv
// Measurement-cycle controller: clear -> gate -> settle -> lock, with
// optional auto-ranging of the gate length (1 s / 100 ms / 10 ms).
// Optional feature macro: FREQ_AUTORANGE_EN (undefined: range fixed at
// RANGE_INIT, low_i ignored, any overflow flagged on ovf_o).
// Ports:
//   clk, rst   : reference clock, synchronous active-high reset
//   run_i      : 1 = back-to-back measurements, 0 = stop after current one
//   ovf_i      : decimal counter carry-out (asynchronous, synchronized here)
//   low_i      : MS counted digit is zero, sampled in LOCK
//   clear_o    : one-cycle counter clear
//   count_en_o : gate, high for exactly the gate length
//   lock_o     : one-cycle result-valid strobe
//   range_o    : range of the measurement being locked
//   ovf_o      : overflow flag, qualified with lock_o
//   busy_o     : high whenever not idle
module freq_gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 27000000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RANGE_INIT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic       ovf_i,
  input  logic       low_i,
  output logic       clear_o,
  output logic       count_en_o,
  output logic       lock_o,
  output logic [1:0] range_o,
  output logic       ovf_o,
  output logic       busy_o
);

  localparam int unsigned TimerW = $clog2(CLK_FREQ_HZ + 1);

  localparam logic [TimerW-1:0] Gate1s    = TimerW'(gate_len(RANGE_1S, CLK_FREQ_HZ));
  localparam logic [TimerW-1:0] Gate100ms = TimerW'(gate_len(RANGE_100MS, CLK_FREQ_HZ));
  localparam logic [TimerW-1:0] Gate10ms  = TimerW'(gate_len(RANGE_10MS, CLK_FREQ_HZ));
  localparam logic [TimerW-1:0] SettleLen = TimerW'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic [1:0]        range_q, range_d, range_next;
  logic              ovf_sync1_q, ovf_sync2_q;
  logic              sticky_q, sticky_d;
  logic              ovf_flag;
  logic              timer_load, timer_en, timer_done;
  logic [TimerW-1:0] timer_val, gate_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      range_q     <= 2'(RANGE_INIT);
      ovf_sync1_q <= 1'b0;
      ovf_sync2_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      ovf_sync1_q <= ovf_i;
      ovf_sync2_q <= ovf_sync1_q;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    gate_sel = Gate10ms;
    case (range_q)
      RANGE_1S:    gate_sel = Gate1s;
      RANGE_100MS: gate_sel = Gate100ms;
      default:     gate_sel = Gate10ms;
    endcase
  end

`ifdef FREQ_AUTORANGE_EN
  always_comb begin
    range_next = range_q;
    if (sticky_q) begin
      if (range_q < RANGE_10MS) begin
        range_next = range_q + 2'd1;
      end
    end else if (low_i && (range_q != RANGE_1S)) begin
      range_next = range_q - 2'd1;
    end
  end

  // Overflow is only reported when no shorter gate is left to try.
  assign ovf_flag = sticky_q && (range_q >= RANGE_10MS);
`else
  logic unused_low;

  assign unused_low = low_i;
  assign range_next = range_q;
  assign ovf_flag   = sticky_q;
`endif

  always_comb begin
    state_d    = state_q;
    range_d    = range_q;
    sticky_d   = sticky_q;
    timer_load = 1'b0;
    timer_val  = gate_sel;
    timer_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StClear;
        end
      end
      StClear: begin
        timer_load = 1'b1;
        timer_val  = gate_sel;
        sticky_d   = 1'b0;
        state_d    = StGate;
      end
      StGate: begin
        timer_en = 1'b1;
        sticky_d = sticky_q | ovf_sync2_q;
        if (timer_done) begin
          // Reload on the last gate cycle so SETTLE starts counting at once.
          timer_load = 1'b1;
          timer_val  = SettleLen;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        timer_en = 1'b1;
        sticky_d = sticky_q | ovf_sync2_q;
        if (timer_done) begin
          state_d = StLock;
        end
      end
      StLock: begin
        range_d = range_next;
        state_d = run_i ? StClear : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  gate_timer #(
    .Width(TimerW)
  ) u_gate_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .en_i      (timer_en),
    .done_o    (timer_done)
  );

  assign clear_o    = (state_q == StClear);
  assign count_en_o = (state_q == StGate);
  assign lock_o     = (state_q == StLock);
  assign ovf_o      = (state_q == StLock) && ovf_flag;
  assign busy_o     = (state_q != StIdle);
  assign range_o    = range_q;

endmodule
